// File: rtl/sar_scan_sequencer.sv
// sar_scan_sequencer
//   Round-robin scan controller for a successive-approximation ADC. For each
//   enabled channel it selects the analog mux input, holds the sample/hold
//   switch closed, releases the SAR register's reset so it converts, and
//   captures the code when the SAR reports done. Results leave through a
//   one-entry valid/ready buffer tagged with their channel.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   enable                1 = keep scanning; 0 = stop after the current conversion
//   ch_mask[NUM_CH]       channels included in the scan
//   sar_done, sar_data    done flag and code from the SAR register
//   sar_reset             holds the SAR register at its initial code while high
//   sample                sample/hold switch closed
//   mux_sel               analog mux channel select
//   result_valid/ready    output buffer handshake
//   result_data/ch        captured code and the channel it came from
//   overrun               sticky: a result was dropped on a full buffer
//   timeout_err           sticky: a conversion never reported done
module sar_scan_sequencer #(
    parameter int SIZE          = 3,
    parameter int NUM_CH        = 4,
    parameter int SAMPLE_CYCLES = 2,
    parameter int TIMEOUT       = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         ch_mask,
    input  logic                      sar_done,
    input  logic [SIZE-1:0]           sar_data,
    output logic                      sar_reset,
    output logic                      sample,
    output logic [$clog2(NUM_CH)-1:0] mux_sel,
    output logic                      result_valid,
    input  logic                      result_ready,
    output logic [SIZE-1:0]           result_data,
    output logic [$clog2(NUM_CH)-1:0] result_ch,
    output logic                      overrun,
    output logic                      timeout_err
);

    localparam int CW  = $clog2(NUM_CH);
    localparam int SCW = $clog2(SAMPLE_CYCLES + 1);
    localparam int TCW = $clog2(TIMEOUT);

    localparam logic [SCW-1:0] SAMP_INIT = SCW'(SAMPLE_CYCLES);
    localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT - 1);
    localparam logic [CW-1:0]  CH_LAST   = CW'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [SCW-1:0]  samp_cnt;
    logic [TCW-1:0]  to_cnt;
    logic [CW-1:0]   last_ch;
    logic [CW-1:0]   pick_ch;
    logic            pick_found;
    logic            start;
    logic            to_fire;
    logic            cap;

    // Round-robin pick: walk offsets from the farthest down to 1 so the
    // nearest enabled channel above last_ch is the last one written.
    always_comb begin
        int          idx;
        logic [CW-1:0] sel;
        pick_found = 1'b0;
        pick_ch    = '0;
        idx        = 0;
        sel        = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = int'(last_ch) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            sel = CW'(idx);
            if (ch_mask[sel]) begin
                pick_found = 1'b1;
                pick_ch    = sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        sar_reset = 1'b1;
        sample    = 1'b0;
        start     = 1'b0;
        to_fire   = 1'b0;
        cap       = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && pick_found) begin
                    start   = 1'b1;
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                sample = 1'b1;
                if (samp_cnt == SCW'(1)) state_d = CONVERT;
            end
            CONVERT: begin
                sar_reset = 1'b0;
                // The SAR is still leaving reset on the first cycle; its done
                // flag is not trustworthy until the counter has moved.
                if (sar_done && (to_cnt != '0)) begin
                    state_d = CAPTURE;
                end else if (to_cnt == TO_LAST) begin
                    to_fire = 1'b1;
                    state_d = IDLE;
                end
            end
            CAPTURE: begin
                cap     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            samp_cnt     <= '0;
            to_cnt       <= '0;
            last_ch      <= CH_LAST;
            mux_sel      <= '0;
            result_valid <= 1'b0;
            result_data  <= '0;
            result_ch    <= '0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            if (start) begin
                mux_sel  <= pick_ch;
                samp_cnt <= SAMP_INIT;
            end else if (state_q == SAMPLE) begin
                samp_cnt <= samp_cnt - SCW'(1);
            end

            if (state_q == CONVERT) to_cnt <= to_cnt + TCW'(1);
            else                    to_cnt <= '0;

            // An abandoned channel still advances the round robin.
            if (to_fire) begin
                timeout_err <= 1'b1;
                last_ch     <= mux_sel;
            end

            if (cap) begin
                last_ch <= mux_sel;
                if (!result_valid || result_ready) begin
                    result_data  <= sar_data;
                    result_ch    <= mux_sel;
                    result_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (result_valid && result_ready) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sar_scan_sequencer.md
Name: sar_scan_sequencer

Overview:
- Multi-channel scan controller that sequences the SAR register through sample, convert and capture for each enabled analog input.
- Drives the analog mux select, the sample/hold switch, and the SAR register's synchronous reset, which acts as its start-of-conversion.
- Captures the SAR result on done and presents it, tagged with its channel, through a one-entry valid/ready output buffer.
- Sits between the SAR register and the downstream consumer (DSP/bus interface).

Parameters:
- SIZE, 3, result width in bits; must equal the attached SAR register's SIZE; SIZE >= 2.
- NUM_CH, 4, number of analog channels; 2..16.
- SAMPLE_CYCLES, 2, clock cycles the sample/hold switch stays closed per conversion; >= 1.
- TIMEOUT, 8, maximum CONVERT cycles before a conversion is abandoned; must be > SIZE.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = run continuous scan; 0 = stop after the current conversion.
- ch_mask  in  NUM_CH  bit i = 1 includes channel i in the scan.
- sar_done  in  1  done from the SAR register.
- sar_data  in  SIZE  digital_out from the SAR register.
- sar_reset  out  1  drives the SAR register's reset; 1 holds it at its initial code.
- sample  out  1  sample/hold switch closed.
- mux_sel  out  $clog2(NUM_CH)  analog mux channel select.
- result_valid  out  1  output buffer holds a result.
- result_ready  in  1  consumer accepts the result.
- result_data  out  SIZE  captured conversion code.
- result_ch  out  $clog2(NUM_CH)  channel of result_data.
- overrun  out  1  sticky: a result was dropped because the buffer was full.
- timeout_err  out  1  sticky: sar_done was not seen within TIMEOUT cycles.

Behaviour:
- Reset values (on reset=1 at a clk edge):
  - state=IDLE, sar_reset=1, sample=0, mux_sel=0.
  - result_valid=0, result_data=0, result_ch=0.
  - overrun=0, timeout_err=0.
  - last_ch=NUM_CH-1, so channel 0 is searched first.
- Reset mid-operation aborts any conversion immediately; no partial result is captured.
- States: IDLE, SAMPLE, CONVERT, CAPTURE.
- IDLE:
  - Outputs: sar_reset=1, sample=0.
  - If enable=1 and ch_mask!=0, pick the next channel round-robin: the lowest enabled index above last_ch, wrapping to 0.
  - On that pick, load mux_sel, set the sample counter to SAMPLE_CYCLES, and go to SAMPLE.
- SAMPLE:
  - Outputs: sar_reset=1, sample=1; mux_sel is stable.
  - The counter decrements each cycle; after exactly SAMPLE_CYCLES cycles, go to CONVERT.
- CONVERT:
  - Outputs: sar_reset=0, sample=0; the timeout counter starts at 0.
  - Each cycle, if sar_done=1, go to CAPTURE.
  - Else, when the counter reaches TIMEOUT-1, set timeout_err=1, return to IDLE, and update last_ch (the channel is skipped).
  - sar_done is ignored on the first CONVERT cycle (SAR still initialising).
- CAPTURE (1 cycle):
  - Output: sar_reset=1.
  - Register sar_data/mux_sel into the output buffer, update last_ch, then go to IDLE.
  - IDLE immediately starts the next channel if enable=1.
- Output buffer:
  - If result_valid=0, or result_ready=1 in the CAPTURE cycle: load data, result_valid=1.
  - If result_valid=1 and result_ready=0 in the CAPTURE cycle: keep the old result, drop the new one, set overrun=1.
  - Outside CAPTURE: result_valid falls to 0 the cycle after result_valid&result_ready.
  - result_data/result_ch are stable while result_valid=1 and result_ready=0.
- ch_mask/enable changes:
  - Sampled only in IDLE; a conversion in flight always completes.
  - ch_mask=0 with enable=1 keeps the block in IDLE.
- Single enabled channel: the same channel is repeated back to back.
- Nominal latency, IDLE to result_valid: 1 + SAMPLE_CYCLES + (SIZE-1) + 1 cycles.
  - With SIZE=3 and SAMPLE_CYCLES=2 that is 6 cycles.
- overrun and timeout_err clear only on reset.

Test Plan:
- Reset → sar_reset=1, result_valid=0, overrun=0, timeout_err=0, mux_sel=0, all held for 3 cycles.
- enable=1, ch_mask=4'b1111, result_ready=1, SAR model outputs channel index+1 → results (ch,data) = (0,1),(1,2),(2,3),(3,4),(0,1); each result_valid pulse is 6 cycles after its IDLE exit.
- ch_mask=4'b1010, start from reset → channel order 1,3,1,3; mux_sel never 0 or 2.
- result_ready=0 for 2 conversions, then 1 → the first result is held unchanged, the second is dropped, overrun=1; once ready, the first result is accepted and overrun stays 1.
- SAR model holds sar_done=0 → timeout_err=1 after 8 CONVERT cycles, no result_valid, scan proceeds to the next channel.
- reset asserted in the 2nd CONVERT cycle → next cycle: state IDLE, sar_reset=1, result_valid=0; the scan restarts at channel 0.
